bus_rr_arbiter: RTL and testbench

//  Round-robin bus arbiter with a lock option. It shares one target bus between N_MASTERS requesters.

---
 rtl/bus_rr_arbiter.sv | 156 +++++++++++++++
 tb/tb_bus_rr_arbiter.sv | 345 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/bus_rr_arbiter.sv
// Round-robin bus arbiter with per-master lock: grant, address setup, wait for
// TargetReady or timeout, one-clock data strobe, then release.
module bus_rr_arbiter #(
  parameter int N_MASTERS    = 4,
  parameter int ADDR_SETUP   = 2,
  parameter int TIMEOUT_CLKS = 12
) (
  input  logic                         clock,
  input  logic                         reset,
  input  logic [N_MASTERS-1:0]         barq,
  input  logic [N_MASTERS-1:0]         block,
  output logic [N_MASTERS-1:0]         bagd,
  output logic                         addressvalid,
  input  logic                         TargetReady,
  output logic                         DataStrobe,
  output logic                         Error,
  output logic [$clog2(N_MASTERS)-1:0] err_master,
  output logic                         busy
);

  localparam int IDX_W   = $clog2(N_MASTERS);
  localparam int SETUP_W = $clog2(ADDR_SETUP + 1);

  localparam logic [SETUP_W-1:0]   SETUP_LAST = SETUP_W'(ADDR_SETUP - 1);
  localparam logic [5:0]           TCNT_LAST  = 6'(TIMEOUT_CLKS - 1);
  localparam logic [IDX_W:0]       N_WIDE     = (IDX_W + 1)'(N_MASTERS);
  localparam logic [N_MASTERS-1:0] ONE_HOT0   = N_MASTERS'(1);

  typedef enum logic [2:0] {
    IDLE,
    SETUP,
    WAIT,
    STROBE,
    RELEASE
  } stateT;

  stateT                state;
  logic [IDX_W-1:0]     grantIdx;
  logic [IDX_W-1:0]     lastGrant;
  logic [IDX_W-1:0]     lockM;
  logic                 lockValid;
  logic                 toFlag;
  logic [SETUP_W-1:0]   setupCnt;
  logic [5:0]           tcnt;

  logic [2*N_MASTERS-1:0] reqTwice;
  logic [2*N_MASTERS-1:0] reqShifted;
  logic [N_MASTERS-1:0]   reqRot;
  logic [IDX_W-1:0]       rrOffset;
  logic                   rrFound;
  logic [IDX_W:0]         rrSum;
  logic [IDX_W-1:0]       rrWinner;
  logic                   lockHit;
  logic [IDX_W-1:0]       winner;

  // Rotate requests so bit 0 is the master just after lastGrant, then take the lowest set bit.
  always_comb begin
    reqTwice   = {barq, barq};
    reqShifted = reqTwice >> ({1'b0, lastGrant} + 1'b1);
    reqRot     = reqShifted[N_MASTERS-1:0];
    rrFound    = 1'b0;
    rrOffset   = '0;
    for (int i = 0; i < N_MASTERS; i++) begin
      if (!rrFound && reqRot[i]) begin
        rrFound  = 1'b1;
        rrOffset = IDX_W'(i);
      end
    end
    rrSum = {1'b0, lastGrant} + (IDX_W + 1)'(1) + {1'b0, rrOffset};
    if (rrSum >= N_WIDE) begin
      rrSum = rrSum - N_WIDE;
    end
    rrWinner = rrSum[IDX_W-1:0];
    lockHit  = lockValid && barq[lockM];
    winner   = lockHit ? lockM : rrWinner;
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state        <= IDLE;
      grantIdx     <= '0;
      lastGrant    <= IDX_W'(N_MASTERS - 1);
      lockM        <= '0;
      lockValid    <= 1'b0;
      toFlag       <= 1'b0;
      setupCnt     <= '0;
      tcnt         <= '0;
      bagd         <= '0;
      addressvalid <= 1'b0;
      DataStrobe   <= 1'b0;
      Error        <= 1'b0;
      err_master   <= '0;
      busy         <= 1'b0;
    end else begin
      DataStrobe <= 1'b0;
      Error      <= 1'b0;
      case (state)
        IDLE: begin
          if (|barq) begin
            state    <= SETUP;
            grantIdx <= winner;
            bagd     <= ONE_HOT0 << winner;
            setupCnt <= '0;
            busy     <= 1'b1;
          end
        end
        SETUP: begin
          if (setupCnt == SETUP_LAST) begin
            state        <= WAIT;
            addressvalid <= 1'b1;
            tcnt         <= '0;
          end else begin
            setupCnt <= setupCnt + 1'b1;
          end
        end
        WAIT: begin
          // A ready target in the timeout-compare cycle still completes cleanly.
          if (TargetReady) begin
            state      <= STROBE;
            toFlag     <= 1'b0;
            DataStrobe <= 1'b1;
          end else if (tcnt == TCNT_LAST) begin
            state      <= STROBE;
            toFlag     <= 1'b1;
            DataStrobe <= 1'b1;
            Error      <= 1'b1;
            err_master <= grantIdx;
          end else if (tcnt != 6'h3F) begin
            tcnt <= tcnt + 1'b1;
          end
        end
        STROBE: begin
          state        <= RELEASE;
          bagd         <= '0;
          addressvalid <= 1'b0;
          lastGrant    <= grantIdx;
          if (block[grantIdx] && barq[grantIdx] && !toFlag) begin
            lockValid <= 1'b1;
            lockM     <= grantIdx;
          end else begin
            lockValid <= 1'b0;
          end
        end
        RELEASE: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_bus_rr_arbiter.sv
// Scoreboard bench for bus_rr_arbiter: each expected strobe (master, error) is
// queued by the scenario and checked by a negedge monitor when DataStrobe fires.
module tb_bus_rr_arbiter;

  localparam int N = 4;

  logic         clock;
  logic         reset;
  logic [N-1:0] barq;
  logic [N-1:0] block;
  logic [N-1:0] bagd;
  logic         addressvalid;
  logic         TargetReady;
  logic         DataStrobe;
  logic         Error;
  logic [1:0]   err_master;
  logic         busy;

  int checks = 0;
  int errors = 0;
  bit monOn  = 1'b0;

  typedef struct {
    int master;
    bit err;
  } expT;

  expT expQ[$];
  expT monExp;
  int  monIdx;

  bus_rr_arbiter #(
    .N_MASTERS(N),
    .ADDR_SETUP(2),
    .TIMEOUT_CLKS(12)
  ) dut (
    .clock(clock),
    .reset(reset),
    .barq(barq),
    .block(block),
    .bagd(bagd),
    .addressvalid(addressvalid),
    .TargetReady(TargetReady),
    .DataStrobe(DataStrobe),
    .Error(Error),
    .err_master(err_master),
    .busy(busy)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Strobe monitor: pops the scoreboard and checks bus sanity every cycle.
  always @(negedge clock) begin
    if (monOn && !reset) begin
      checks++;
      if (!$onehot0(bagd) || (Error === 1'b1 && DataStrobe !== 1'b1)) begin
        errors++;
        $display("FAIL bus_sanity: bagd=%b Error=%b DataStrobe=%b, want at most one grant and Error only with DataStrobe",
                 bagd, Error, DataStrobe);
      end
      if (DataStrobe === 1'b1) begin
        checks++;
        if (expQ.size() == 0) begin
          errors++;
          $display("FAIL unexpected_strobe: DataStrobe=1 with bagd=%b, want no strobe", bagd);
        end else begin
          monExp = expQ.pop_front();
          monIdx = -1;
          for (int i = 0; i < N; i++) begin
            if (bagd[i]) monIdx = i;
          end
          if (monIdx != monExp.master || Error !== monExp.err || addressvalid !== 1'b1) begin
            errors++;
            $display("FAIL strobe: master=%0d Error=%b addressvalid=%b, want master=%0d Error=%b addressvalid=1",
                     monIdx, Error, addressvalid, monExp.master, monExp.err);
          end else begin
            $display("strobe: master=%0d Error=%b", monIdx, Error);
          end
        end
      end
    end
  end

  task automatic doReset;
    @(negedge clock);
    reset = 1'b1;
    barq = '0;
    block = '0;
    TargetReady = 1'b0;
    @(negedge clock);
    reset = 1'b0;
  endtask

  task automatic waitStrobe(output int waited);
    waited = 0;
    do begin
      @(negedge clock);
      waited++;
    end while (DataStrobe !== 1'b1 && waited < 200);
    if (DataStrobe !== 1'b1) begin
      checks++;
      errors++;
      $display("FAIL strobe_timeout: DataStrobe=%b after %0d clocks, want 1", DataStrobe, waited);
    end
  endtask

  task automatic waitAv;
    int n;
    n = 0;
    while (addressvalid !== 1'b1 && n < 50) begin
      @(negedge clock);
      n++;
    end
    if (addressvalid !== 1'b1) begin
      checks++;
      errors++;
      $display("FAIL av_timeout: addressvalid=%b, want 1", addressvalid);
    end
  endtask

  task automatic test_reset;
    reset = 1'b1;
    barq = '0;
    block = '0;
    TargetReady = 1'b0;
    repeat (2) @(negedge clock);
    checks += 6;
    if (bagd !== '0)         begin errors++; $display("FAIL reset_bagd: got %b, want 0000", bagd); end
    if (addressvalid !== 0)  begin errors++; $display("FAIL reset_av: got %b, want 0", addressvalid); end
    if (DataStrobe !== 0)    begin errors++; $display("FAIL reset_strobe: got %b, want 0", DataStrobe); end
    if (Error !== 0)         begin errors++; $display("FAIL reset_error: got %b, want 0", Error); end
    if (err_master !== 0)    begin errors++; $display("FAIL reset_err_master: got %0d, want 0", err_master); end
    if (busy !== 0)          begin errors++; $display("FAIL reset_busy: got %b, want 0", busy); end
    reset = 1'b0;
    monOn = 1'b1;
    repeat (2) @(negedge clock);
    checks++;
    if (busy !== 0 || bagd !== '0) begin
      errors++;
      $display("FAIL idle_no_req: busy=%b bagd=%b, want 0 and 0000", busy, bagd);
    end
    $display("test_reset done");
  endtask

  task automatic test_single;
    barq = 4'b0001;
    TargetReady = 1'b0;
    expQ.push_back('{master: 0, err: 1'b0});
    @(negedge clock);
    checks += 2;
    if (bagd !== 4'b0001) begin errors++; $display("FAIL single_grant: got %b, want 0001", bagd); end
    if (busy !== 1'b1)    begin errors++; $display("FAIL single_busy: got %b, want 1", busy); end
    barq = '0;
    @(negedge clock);
    checks++;
    if (addressvalid !== 1'b0) begin errors++; $display("FAIL single_av_early: got %b, want 0", addressvalid); end
    @(negedge clock);
    checks++;
    if (addressvalid !== 1'b1) begin errors++; $display("FAIL single_av_rise: got %b, want 1", addressvalid); end
    repeat (3) @(negedge clock);
    TargetReady = 1'b1;
    @(negedge clock);
    checks++;
    if (DataStrobe !== 1'b1 || Error !== 1'b0) begin
      errors++;
      $display("FAIL single_strobe: DataStrobe=%b Error=%b, want 1 0", DataStrobe, Error);
    end
    TargetReady = 1'b0;
    @(negedge clock);
    checks++;
    if (bagd !== '0 || addressvalid !== 0 || DataStrobe !== 0 || busy !== 1) begin
      errors++;
      $display("FAIL single_release: bagd=%b av=%b ds=%b busy=%b, want 0000 0 0 1", bagd, addressvalid, DataStrobe, busy);
    end
    @(negedge clock);
    checks++;
    if (busy !== 1'b0) begin errors++; $display("FAIL single_idle_busy: got %b, want 0", busy); end
    $display("test_single done");
  endtask

  task automatic test_back_to_back;
    int gap;
    int order[5] = '{0, 1, 2, 3, 0};
    doReset();
    for (int k = 0; k < 5; k++) expQ.push_back('{master: order[k], err: 1'b0});
    barq = 4'b1111;
    TargetReady = 1'b1;
    for (int k = 0; k < 5; k++) begin
      waitStrobe(gap);
      if (k > 0) begin
        checks++;
        if (gap != 6) begin
          errors++;
          $display("FAIL b2b_spacing: strobe %0d came %0d clocks after previous, want 6", k, gap);
        end
      end
    end
    barq = '0;
    TargetReady = 1'b0;
    repeat (3) @(negedge clock);
    checks++;
    if (busy !== 1'b0) begin errors++; $display("FAIL b2b_idle: busy=%b, want 0", busy); end
    $display("test_back_to_back done");
  endtask

  task automatic test_timeout;
    barq = 4'b0100;
    TargetReady = 1'b0;
    expQ.push_back('{master: 2, err: 1'b1});
    @(negedge clock);
    checks++;
    if (bagd !== 4'b0100) begin errors++; $display("FAIL to_grant: got %b, want 0100", bagd); end
    barq = '0;
    waitAv();
    repeat (11) @(negedge clock);
    checks++;
    if (DataStrobe !== 1'b0) begin errors++; $display("FAIL to_early: DataStrobe=%b at 11 clocks, want 0", DataStrobe); end
    @(negedge clock);
    checks++;
    if (DataStrobe !== 1'b1 || Error !== 1'b1) begin
      errors++;
      $display("FAIL to_strobe: DataStrobe=%b Error=%b at 12 clocks, want 1 1", DataStrobe, Error);
    end
    @(negedge clock);
    checks += 2;
    if (Error !== 1'b0 || DataStrobe !== 1'b0) begin
      errors++;
      $display("FAIL to_pulse_width: DataStrobe=%b Error=%b, want 0 0", DataStrobe, Error);
    end
    if (err_master !== 2'd2) begin errors++; $display("FAIL to_err_master: got %0d, want 2", err_master); end
    repeat (2) @(negedge clock);
    $display("test_timeout done");
  endtask

  task automatic test_timeout_race;
    barq = 4'b0001;
    TargetReady = 1'b0;
    expQ.push_back('{master: 0, err: 1'b0});
    @(negedge clock);
    barq = '0;
    waitAv();
    repeat (11) @(negedge clock);
    TargetReady = 1'b1;
    @(negedge clock);
    checks++;
    if (DataStrobe !== 1'b1 || Error !== 1'b0) begin
      errors++;
      $display("FAIL race_strobe: DataStrobe=%b Error=%b, want 1 0", DataStrobe, Error);
    end
    TargetReady = 1'b0;
    @(negedge clock);
    checks++;
    if (err_master !== 2'd2) begin errors++; $display("FAIL race_err_master: got %0d, want 2", err_master); end
    repeat (2) @(negedge clock);
    $display("test_timeout_race done");
  endtask

  task automatic test_lock;
    int gap;
    int order[6] = '{0, 1, 2, 2, 2, 3};
    doReset();
    for (int k = 0; k < 6; k++) expQ.push_back('{master: order[k], err: 1'b0});
    block = 4'b0100;
    barq = 4'b1111;
    TargetReady = 1'b1;
    for (int k = 0; k < 6; k++) begin
      waitStrobe(gap);
      if (k == 4) block = '0;
    end
    barq = '0;
    TargetReady = 1'b0;
    repeat (3) @(negedge clock);

    // A locked cycle that times out must give up the lock.
    doReset();
    expQ.push_back('{master: 2, err: 1'b0});
    expQ.push_back('{master: 2, err: 1'b1});
    expQ.push_back('{master: 3, err: 1'b0});
    block = 4'b0100;
    barq = 4'b0100;
    TargetReady = 1'b1;
    waitStrobe(gap);
    barq = 4'b1111;
    TargetReady = 1'b0;
    waitStrobe(gap);
    TargetReady = 1'b1;
    waitStrobe(gap);
    barq = '0;
    block = '0;
    TargetReady = 1'b0;
    repeat (3) @(negedge clock);
    checks++;
    if (busy !== 1'b0) begin errors++; $display("FAIL lock_idle: busy=%b, want 0", busy); end
    $display("test_lock done");
  endtask

  task automatic test_reset_mid_wait;
    int gap;
    barq = 4'b0010;
    TargetReady = 1'b0;
    @(negedge clock);
    barq = '0;
    waitAv();
    repeat (2) @(negedge clock);
    #2 reset = 1'b1;
    #1;
    checks += 4;
    if (bagd !== '0)          begin errors++; $display("FAIL midrst_bagd: got %b, want 0000", bagd); end
    if (addressvalid !== 1'b0) begin errors++; $display("FAIL midrst_av: got %b, want 0", addressvalid); end
    if (DataStrobe !== 1'b0)  begin errors++; $display("FAIL midrst_strobe: got %b, want 0", DataStrobe); end
    if (busy !== 1'b0)        begin errors++; $display("FAIL midrst_busy: got %b, want 0", busy); end
    @(negedge clock);
    reset = 1'b0;
    barq = 4'b1010;
    TargetReady = 1'b1;
    expQ.push_back('{master: 1, err: 1'b0});
    @(negedge clock);
    checks++;
    if (bagd !== 4'b0010) begin errors++; $display("FAIL midrst_first_grant: got %b, want 0010", bagd); end
    barq = '0;
    waitStrobe(gap);
    TargetReady = 1'b0;
    repeat (3) @(negedge clock);
    $display("test_reset_mid_wait done");
  endtask

  initial begin
    test_reset();
    test_single();
    test_back_to_back();
    test_timeout();
    test_timeout_race();
    test_lock();
    test_reset_mid_wait();
    checks++;
    if (expQ.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain: %0d strobes still expected, want 0", expQ.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
